// File: rtl/md_unit_e.sv
// rtl/md_unit_e.sv - multi-cycle multiply/divide unit with HI/LO registers
//
// Purpose: executes mult, multu, div, divu (and madd/msub when MD_MADD_EN is
// defined) over a fixed number of busy cycles, then writes HI/LO. HI/LO can
// also be loaded directly with mthi/mtlo while the unit is idle.
//
// Optional feature macro: MD_MADD_EN enables ops 4 (madd) and 5 (msub).
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   start     in   launch request for op
//   op        in   3-bit operation select
//   a, b      in   WIDTH-bit operands (rs, rt)
//   mthi/mtlo in   write wdata into HI / LO
//   wdata     in   WIDTH-bit move data
//   busy      out  operation in progress
//   md_stall  out  start | busy, for decode-stage stall
//   hi, lo    out  HI / LO registers
module md_unit_e #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             md_stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int         W2     = 2 * WIDTH;
    localparam logic [7:0] MULT_N = 8'(MULT_CYCLES);
    localparam logic [7:0] DIV_N  = 8'(DIV_CYCLES);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_legal;
    logic             w_launch;
    logic             w_done;
    logic             w_move;
    logic             w_wr_res;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    always_comb begin
        w_legal = 1'b0;
        case (op)
            3'd0, 3'd1, 3'd2, 3'd3: w_legal = 1'b1;
`ifdef MD_MADD_EN
            3'd4, 3'd5:             w_legal = 1'b1;
`endif
            default:                w_legal = 1'b0;
        endcase
    end

    assign w_launch = (r_state == S_IDLE) && start && w_legal;
    // Counter hits zero on this edge: result is written as the FSM leaves BUSY.
    assign w_done   = (r_state == S_BUSY) && (r_cnt == 8'd1);
    // start has priority over a move, whether or not its op is legal.
    assign w_move   = (r_state == S_IDLE) && !start && (mthi || mtlo);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_next = S_BUSY;
            S_BUSY:  if (w_done)   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Low 2W bits of a product of sign-extended operands equal the signed product.
    logic [W2-1:0] w_sprod;
    logic [W2-1:0] w_uprod;
    assign w_sprod = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_uprod = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

    // Signed division via magnitudes; the most-negative magnitude still fits
    // as an unsigned value, so MIN / -1 naturally yields MIN with remainder 0.
    logic             w_sgn;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_divisor;
    logic [WIDTH-1:0] w_q_mag;
    logic [WIDTH-1:0] w_r_mag;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;

    assign w_sgn     = (r_op == 3'd2);
    assign w_a_neg   = w_sgn && r_a[WIDTH-1];
    assign w_b_neg   = w_sgn && r_b[WIDTH-1];
    assign w_b_zero  = (r_b == '0);
    assign w_a_mag   = w_a_neg ? -r_a : r_a;
    assign w_b_mag   = w_b_neg ? -r_b : r_b;
    // Divisor forced nonzero; the zero case never writes its result.
    assign w_divisor = w_b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_b_mag;
    assign w_q_mag   = w_a_mag / w_divisor;
    assign w_r_mag   = w_a_mag % w_divisor;
    assign w_q       = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    assign w_r       = w_a_neg ? -w_r_mag : w_r_mag;

    always_comb begin
        w_wr_res = 1'b1;
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (r_op)
            3'd0: {w_res_hi, w_res_lo} = w_sprod;
            3'd1: {w_res_hi, w_res_lo} = w_uprod;
            3'd2, 3'd3: begin
                if (w_b_zero) w_wr_res = 1'b0;
                else          {w_res_hi, w_res_lo} = {w_r, w_q};
            end
`ifdef MD_MADD_EN
            3'd4: {w_res_hi, w_res_lo} = {r_hi, r_lo} + w_sprod;
            3'd5: {w_res_hi, w_res_lo} = {r_hi, r_lo} - w_sprod;
`endif
            default: w_wr_res = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_op    <= 3'd0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_next;
            if (w_launch) begin
                r_a   <= a;
                r_b   <= b;
                r_op  <= op;
                r_cnt <= (op == 3'd2 || op == 3'd3) ? DIV_N : MULT_N;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_done && w_wr_res) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (w_move) begin
                if (mthi) r_hi <= wdata;
                if (mtlo) r_lo <= wdata;
            end
        end
    end

    assign busy     = (r_state == S_BUSY);
    assign md_stall = start || busy;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: doc/md_unit_e.md
MD_UNIT_E -- requirements
Module: md_unit_e

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width in bits.
REQ-002 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu (legal range 1..255).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu (legal range 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  launch request for the operation on op, qualified on a rising edge.
REQ-007 SHALL have port op  input  3  operation select: 0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 msub; 6 and 7 are reserved.
REQ-008 SHALL have port a  input  WIDTH  rs operand (multiplicand or dividend).
REQ-009 SHALL have port b  input  WIDTH  rt operand (multiplier or divisor).
REQ-010 SHALL have port mthi  input  1  write wdata into HI.
REQ-011 SHALL have port mtlo  input  1  write wdata into LO.
REQ-012 SHALL have port wdata  input  WIDTH  data for mthi and mtlo.
REQ-013 SHALL have port busy  output  1  operation in progress.
REQ-014 SHALL have port md_stall  output  1  combinational start OR busy, driven to the decode-stage stall logic.
REQ-015 SHALL have port hi  output  WIDTH  HI register.
REQ-016 SHALL have port lo  output  WIDTH  LO register.

Function
REQ-017 SHALL implement states IDLE and BUSY; busy SHALL be high exactly when the state is BUSY.
REQ-018 In IDLE, start=1 with a legal op SHALL latch a, b and op, load the down-counter with N (MULT_CYCLES for ops 0, 1, 4, 5; DIV_CYCLES for ops 2, 3), and enter BUSY.
REQ-019 In IDLE, start=1 with a reserved op SHALL be ignored: no state change.
REQ-020 In BUSY, the counter SHALL decrement on every edge; on the edge where it reaches 0, hi and lo SHALL update and the state SHALL return to IDLE, so busy is high for exactly N cycles.
REQ-021 mult/multu SHALL write the 2*WIDTH product, signed or unsigned respectively: hi gets the upper half, lo the lower half.
REQ-022 div/divu SHALL write quotient to lo and remainder to hi; signed division SHALL truncate toward zero, with the remainder taking the sign of the dividend.
REQ-023 Divide by zero SHALL complete with normal latency and leave hi and lo unchanged.
REQ-024 Signed most-negative divided by -1 SHALL give lo = most-negative and hi = 0.
REQ-025 Inputs a and b SHALL NOT affect a result after the launch edge.
REQ-026 start while BUSY SHALL be ignored; it SHALL NOT restart or queue an operation.
REQ-027 mthi/mtlo in IDLE SHALL write hi/lo on the next edge; mthi and mtlo together SHALL write both.
REQ-028 mthi/mtlo while BUSY SHALL be ignored.
REQ-029 When start and mthi/mtlo are both high in IDLE, start SHALL take priority and the move SHALL be ignored.
REQ-030 md_stall SHALL be high in the launch cycle and in all BUSY cycles.

Reset
REQ-031 reset low SHALL immediately force IDLE, busy=0, hi=0, lo=0 and counter=0, regardless of clk.
REQ-032 reset asserted mid-operation SHALL discard the pending result.
REQ-033 After reset deasserts, the first rising edge SHALL accept start normally.

Configuration
REQ-034 With MD_MADD_EN defined, ops 4 (madd) and 5 (msub) SHALL add or subtract the signed product to or from {hi,lo}, modulo 2^(2*WIDTH), with MULT_CYCLES latency; {hi,lo} is sampled at completion.
REQ-035 Without MD_MADD_EN, ops 4 and 5 SHALL be treated as reserved per REQ-019, and no accumulate adder SHALL be synthesised.

Verification
REQ-036 mult a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-037 multu a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
REQ-038 div a=-7 (0xFFFFFFF9), b=2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7, b=0 with prior hi=0x11, lo=0x22 -> hi and lo unchanged.
REQ-039 Start div, pulse start with mult on busy cycle 3, pulse mthi wdata=0x55 on busy cycle 4 -> div result only, busy high exactly 10 cycles, hi not equal to 0x55.
REQ-040 Start mult, assert reset low on busy cycle 2 -> busy=0, hi=lo=0 immediately, and no later update.
REQ-041 With MD_MADD_EN: hi=0, lo=0xFFFFFFFF, madd a=1, b=1 -> hi=1, lo=0; without MD_MADD_EN the same op leaves busy=0 and hi/lo unchanged.
